// File: rtl/ps2_host_tx_if.sv
// ----------------------------------------------------------------------------
// ps2_host_tx_if
// Command/status bundle between the game logic and the PS/2 host transmitter.
//   cmd_data  [7:0]  command byte to send (master -> slave)
//   cmd_valid        send request, taken when cmd_ready=1 (master -> slave)
//   cmd_ready        transmitter idle and able to take a byte (slave -> master)
//   busy             transfer in progress (slave -> master)
//   tx_done          1-cycle pulse: byte sent and device ACK seen
//   tx_error         1-cycle pulse: timeout or missing ACK
// ----------------------------------------------------------------------------
interface ps2_host_tx_if;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output cmd_data, cmd_valid,
      input  cmd_ready, busy, tx_done, tx_error
   );

   modport slave (
      input  cmd_data, cmd_valid,
      output cmd_ready, busy, tx_done, tx_error
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to the keyboard:
// clock inhibit, request-to-send, 8 data bits LSB first, odd parity, stop bit,
// then checks the device ACK. Both bus lines are open-drain (0 or 'z').
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset; releases both bus lines at once
//   cmd_if      command/status bundle (slave side)
//   ps2_clk_io  PS/2 clock line, open-drain
//   ps2_dat_io  PS/2 data line, open-drain
// ----------------------------------------------------------------------------
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_TIMEOUT  = 750000,
   parameter int PACKET_TIMEOUT = 100000
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   ps2_host_tx_if.slave cmd_if,
   inout  wire          ps2_clk_io,
   inout  wire          ps2_dat_io
);

   localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
   localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
   localparam logic [19:0] PACKET_LAST  = 20'(PACKET_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WREL, S_DONE, S_ERR
   } state_e;

   state_e      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [8:0]  shreg_q, shreg_d;
   logic        dat_low_q, dat_low_d;
   logic [1:0]  clk_sync_q, dat_sync_q;
   logic        clk_prev_q;

   logic        clk_s, dat_s, clk_fall;
   logic [19:0] cnt_inc;

   assign clk_s    = clk_sync_q[1];
   assign dat_s    = dat_sync_q[1];
   assign clk_fall = clk_prev_q & ~clk_s;
   // Saturating increment: the shared timer can never wrap back into range.
   assign cnt_inc  = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         dat_low_q  <= 1'b0;
         clk_sync_q <= 2'b11;
         dat_sync_q <= 2'b11;
         clk_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         dat_low_q  <= dat_low_d;
         clk_sync_q <= {clk_sync_q[0], ps2_clk_io};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_io};
         clk_prev_q <= clk_s;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_inc;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      dat_low_d = dat_low_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (cmd_if.cmd_valid) begin
               state_d   = S_INHIBIT;
               shreg_d   = {~^cmd_if.cmd_data, cmd_if.cmd_data};
               bit_cnt_d = '0;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == INHIBIT_LAST) begin
               state_d   = S_REQ;
               cnt_d     = '0;
               dat_low_d = 1'b1;          // start bit
            end
         end
         S_REQ: begin
            if (clk_fall) begin
               // First device edge: put D0 on the line; packet timer starts here.
               state_d   = S_DATA;
               cnt_d     = '0;
               dat_low_d = ~shreg_q[0];
               shreg_d   = {1'b1, shreg_q[8:1]};
               bit_cnt_d = 4'd1;
            end else if (cnt_q == START_LAST) begin
               state_d = S_ERR;
            end
         end
         S_DATA: begin
            if (cnt_q == PACKET_LAST) begin
               state_d = S_ERR;
            end else if (clk_fall) begin
               if (bit_cnt_q == 4'd9) begin
                  // Edge 10: release data for the stop bit.
                  state_d   = S_ACK;
                  dat_low_d = 1'b0;
               end else begin
                  dat_low_d = ~shreg_q[0];
                  shreg_d   = {1'b1, shreg_q[8:1]};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_ACK: begin
            if (cnt_q == PACKET_LAST) begin
               state_d = S_ERR;
            end else if (clk_fall) begin
               state_d = dat_s ? S_ERR : S_WREL;
            end
         end
         S_WREL: begin
            if (cnt_q == PACKET_LAST) begin
               state_d = S_ERR;
            end else if (clk_s && dat_s) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Data is only ever pulled low while sending the start/data/parity bits.
      if (state_d != S_REQ && state_d != S_DATA) begin
         dat_low_d = 1'b0;
      end
   end

   assign cmd_if.cmd_ready = (state_q == S_IDLE);
   assign cmd_if.busy      = (state_q != S_IDLE);
   assign cmd_if.tx_done   = (state_q == S_DONE);
   assign cmd_if.tx_error  = (state_q == S_ERR);

   // Open-drain drivers: low or released, never driven high.
   assign ps2_clk_io = (state_q == S_INHIBIT) ? 1'b0 : 1'bz;
   assign ps2_dat_io = dat_low_q ? 1'b0 : 1'bz;

endmodule
